// File: rtl/dma_desc_writeback_if.sv
// Completion channel from the data mover plus the AVMM write master that
// carries the descriptor write-back burst.
interface dma_desc_writeback_if;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [31:0] wb_desc_addr_i;
    logic [31:0] wb_status_i;
    logic [31:0] wb_ctrl_i;
    logic        dma_desc_wb_write_o;
    logic [31:0] dma_desc_wb_addr_o;
    logic [3:0]  dma_desc_wb_bcount_o;
    logic [31:0] dma_desc_wb_wrdata_o;
    logic        dma_desc_wb_waitrequest_i;

    // Environment side: the data mover offers completions, memory answers with waitrequest.
    modport master (
        output wb_valid_i,
        output wb_desc_addr_i,
        output wb_status_i,
        output wb_ctrl_i,
        output dma_desc_wb_waitrequest_i,
        input  wb_ready_o,
        input  dma_desc_wb_write_o,
        input  dma_desc_wb_addr_o,
        input  dma_desc_wb_bcount_o,
        input  dma_desc_wb_wrdata_o
    );

    modport slave (
        input  wb_valid_i,
        input  wb_desc_addr_i,
        input  wb_status_i,
        input  wb_ctrl_i,
        input  dma_desc_wb_waitrequest_i,
        output wb_ready_o,
        output dma_desc_wb_write_o,
        output dma_desc_wb_addr_o,
        output dma_desc_wb_bcount_o,
        output dma_desc_wb_wrdata_o
    );
endinterface

// File: rtl/dma_desc_writeback.sv
// Descriptor write-back: writes status (word 6) then ctrl with ownership cleared
// (word 7) as a 2-beat AVMM burst, then counts the completion and pulses the IRQ.
module dma_desc_writeback #(
    parameter int OWN_BIT = 31,
    parameter int IRQ_BIT = 30,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          csr_control_i,
    dma_desc_writeback_if.slave  bus,
    output logic [CNT_W-1:0]     dma_desc_done_count_o,
    output logic                 dma_desc_irq_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_STATUS = 2'd1,
        WR_CTRL   = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam logic [31:0] OWN_MASK = 32'h1 << OWN_BIT;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             write;
    logic             beat_accept;
    logic             unused_inputs;

    assign write       = (state_q == WR_STATUS) || (state_q == WR_CTRL);
    assign beat_accept = write && !bus.dma_desc_wb_waitrequest_i;

    // The burst address and first beat's data are loaded straight into the output
    // registers at handshake, so they already hold the latched values on the bus.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wb_valid_i && ready_q) begin
                    addr_d  = {bus.wb_desc_addr_i[31:5], 5'b11000};
                    data_d  = bus.wb_status_i;
                    ctrl_d  = bus.wb_ctrl_i & ~OWN_MASK;
                    state_d = WR_STATUS;
                end
            end
            WR_STATUS: begin
                if (beat_accept) begin
                    data_d  = ctrl_q;
                    state_d = WR_CTRL;
                end
            end
            WR_CTRL: begin
                if (beat_accept) begin
                    count_d = count_q + 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // The IRQ enable is deliberately looked at only during DONE.
    assign dma_desc_irq_o        = (state_q == DONE) && ctrl_q[IRQ_BIT] && csr_control_i[4];
    assign dma_desc_done_count_o = count_q;

    assign bus.wb_ready_o           = ready_q;
    assign bus.dma_desc_wb_write_o  = write;
    assign bus.dma_desc_wb_addr_o   = addr_q;
    assign bus.dma_desc_wb_bcount_o = 4'h2;
    assign bus.dma_desc_wb_wrdata_o = data_q;

    assign unused_inputs = ^{csr_control_i[31:5], csr_control_i[3:0], bus.wb_desc_addr_i[4:0]};

endmodule

// File: tb/tb_dma_desc_writeback.sv
// Randomized bench for dma_desc_writeback: a memory-side monitor collects accepted
// beats and injects waitrequest stalls; each test compares against a simple model.
module tb_dma_desc_writeback;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      csr;
    logic [CNT_W-1:0] count;
    logic             irq;

    dma_desc_writeback_if bus ();

    dma_desc_writeback #(.OWN_BIT(31), .IRQ_BIT(30), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .csr_control_i         (csr),
        .bus                   (bus),
        .dma_desc_done_count_o (count),
        .dma_desc_irq_o        (irq)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    int          stall_plan[$];
    int          stall_left = -1;
    int          stall_total = 0;
    int          unstable_cnt = 0;
    bit          rand_stalls = 1'b0;
    logic [31:0] snap_addr, snap_data;
    int          exp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: decides waitrequest mid-cycle for the beat on the bus, records
    // accepted beats and notes any beat that changes while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            stall_left = -1;
            bus.dma_desc_wb_waitrequest_i = 1'b0;
        end else if (bus.dma_desc_wb_write_o) begin
            if (stall_left < 0) begin
                if (stall_plan.size() > 0) stall_left = stall_plan.pop_front();
                else if (rand_stalls)      stall_left = int'($urandom_range(0, 2));
                else                       stall_left = 0;
                snap_addr = bus.dma_desc_wb_addr_o;
                snap_data = bus.dma_desc_wb_wrdata_o;
            end else if (bus.dma_desc_wb_addr_o !== snap_addr || bus.dma_desc_wb_wrdata_o !== snap_data) begin
                unstable_cnt++;
            end
            if (stall_left > 0) begin
                bus.dma_desc_wb_waitrequest_i = 1'b1;
                stall_left--;
                stall_total++;
            end else begin
                bus.dma_desc_wb_waitrequest_i = 1'b0;
                obs_q.push_back({bus.dma_desc_wb_addr_o, bus.dma_desc_wb_wrdata_o});
                stall_left = -1;
            end
        end else begin
            if (stall_left >= 0) unstable_cnt++;
            stall_left = -1;
            bus.dma_desc_wb_waitrequest_i = 1'b0;
        end
    end

    // Offers one descriptor (called at a negedge), updates the model, scrambles the
    // inputs after the handshake and waits for ready. lat counts cycles from the
    // handshake cycle to the first ready cycle.
    task automatic run_one(input logic [31:0] a, input logic [31:0] s, input logic [31:0] c,
                           output int lat, output int irq_cyc, output bit ok);
        int n = 0;
        bus.wb_valid_i     = 1'b1;
        bus.wb_desc_addr_i = a;
        bus.wb_status_i    = s;
        bus.wb_ctrl_i      = c;
        while (!bus.wb_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = 0;
        irq_cyc = 0;
        ok = bus.wb_ready_o;
        if (!ok) return;
        exp_q.push_back({(a & 32'hFFFF_FFE0) | 32'h18, s});
        exp_q.push_back({(a & 32'hFFFF_FFE0) | 32'h18, c & 32'h7FFF_FFFF});
        exp_count = (exp_count + 1) % (1 << CNT_W);
        @(negedge clk);
        bus.wb_valid_i     = 1'b0;
        bus.wb_desc_addr_i = $urandom();
        bus.wb_status_i    = $urandom();
        bus.wb_ctrl_i      = $urandom();
        lat = 1;
        while (!bus.wb_ready_o && lat < 200) begin
            if (irq) irq_cyc++;
            @(negedge clk);
            lat++;
        end
        ok = bus.wb_ready_o;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        csr = 32'h0;
        bus.wb_valid_i = 1'b0;
        bus.wb_desc_addr_i = 32'h0;
        bus.wb_status_i = 32'h0;
        bus.wb_ctrl_i = 32'h0;
        bus.dma_desc_wb_waitrequest_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dma_desc_wb_write_o !== 1'b0 || bus.wb_ready_o !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctl write=%b ready=%b irq=%b required 0/0/0", bus.dma_desc_wb_write_o, bus.wb_ready_o, irq);
        end
        checks++;
        if (bus.dma_desc_wb_addr_o !== 32'h0 || bus.dma_desc_wb_wrdata_o !== 32'h0 || count !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data addr=%h data=%h count=%0d required 0", bus.dma_desc_wb_addr_o, bus.dma_desc_wb_wrdata_o, count);
        end
        checks++;
        if (bus.dma_desc_wb_bcount_o !== 4'h2) begin
            failures++;
            $display("[TB] FAIL bcount got=%h required=2", bus.dma_desc_wb_bcount_o);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.wb_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready got=%b required=1", bus.wb_ready_o);
        end
        exp_count = 0;
    endtask

    task automatic test_single();
        int lat, irqc;
        bit ok;
        obs_q.delete(); exp_q.delete(); stall_plan.delete();
        unstable_cnt = 0;
        csr = 32'h10;
        run_one(32'h0000_1000, 32'h0000_0200, 32'h8000_0001, lat, irqc, ok);
        checks++;
        if (!ok || lat != 4) begin
            failures++;
            $display("[TB] FAIL single_latency got=%0d ok=%b required=4", lat, ok);
        end
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 64'h0000_1018_0000_0200 || obs_q[1] !== 64'h0000_1018_0000_0001) begin
            failures++;
            $display("[TB] FAIL single_beats got=%0d beats first=%h required 2 beats 0000101800000200,0000101800000001",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0);
        end
        checks++;
        if (int'(count) !== exp_count || irqc != 0) begin
            failures++;
            $display("[TB] FAIL single_count_irq count=%0d irq_cycles=%0d required %0d/0", count, irqc, exp_count);
        end
    endtask

    task automatic test_irq();
        int lat, irqc;
        bit ok;
        obs_q.delete(); exp_q.delete();
        csr = 32'h10;
        run_one(32'h0000_3000, 32'h0000_0040, 32'hC000_0000, lat, irqc, ok);
        checks++;
        if (!ok || irqc != 1 || obs_q.size() != 2 || obs_q[obs_q.size()-1] !== 64'h0000_3018_4000_0000) begin
            failures++;
            $display("[TB] FAIL irq_enabled irq_cycles=%0d beats=%0d required 1 pulse and ctrl beat 40000000", irqc, obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
        csr = 32'h0;
        run_one(32'h0000_3020, 32'h0000_0041, 32'hC000_0000, lat, irqc, ok);
        checks++;
        if (!ok || irqc != 0 || int'(count) !== exp_count) begin
            failures++;
            $display("[TB] FAIL irq_disabled irq_cycles=%0d count=%0d required 0/%0d", irqc, count, exp_count);
        end
    endtask

    task automatic test_stall();
        int lat, irqc;
        bit ok;
        obs_q.delete(); exp_q.delete();
        unstable_cnt = 0;
        csr = 32'h10;
        stall_plan = '{3, 2};
        run_one(32'h0000_4000, 32'hDEAD_0001, 32'h8000_00AA, lat, irqc, ok);
        checks++;
        if (!ok || lat != 9) begin
            failures++;
            $display("[TB] FAIL stall_latency got=%0d required=9", lat);
        end
        checks++;
        if (unstable_cnt != 0) begin
            failures++;
            $display("[TB] FAIL stall_stability unstable_cycles=%0d required=0", unstable_cnt);
        end
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 64'h0000_4018_DEAD_0001 || obs_q[1] !== 64'h0000_4018_0000_00AA) begin
            failures++;
            $display("[TB] FAIL stall_beats got=%0d beats first=%h required 2 beats status then ctrl",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0);
        end
    endtask

    task automatic test_back_to_back();
        int hs[3];
        int n;
        logic [31:0] a, s, c;
        obs_q.delete(); exp_q.delete(); stall_plan.delete();
        csr = 32'h10;
        bus.wb_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h0000_2017 + 32'(i) * 32'h20;
            s = $urandom();
            c = $urandom();
            bus.wb_desc_addr_i = a;
            bus.wb_status_i = s;
            bus.wb_ctrl_i = c;
            n = 0;
            while (!bus.wb_ready_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            hs[i] = cyc;
            exp_q.push_back({(a & 32'hFFFF_FFE0) | 32'h18, s});
            exp_q.push_back({(a & 32'hFFFF_FFE0) | 32'h18, c & 32'h7FFF_FFFF});
            exp_count = (exp_count + 1) % (1 << CNT_W);
            @(negedge clk);
        end
        bus.wb_valid_i = 1'b0;
        n = 0;
        while (!bus.wb_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (hs[1] - hs[0] != 4 || hs[2] - hs[1] != 4 || !bus.wb_ready_o) begin
            failures++;
            $display("[TB] FAIL b2b_spacing gaps=%0d,%0d required 4,4", hs[1] - hs[0], hs[2] - hs[1]);
        end
        checks++;
        if (obs_q.size() != 6 || obs_q[0][63:32] !== 32'h0000_2018) begin
            failures++;
            $display("[TB] FAIL b2b_unaligned beats=%0d first_addr=%h required 6 beats at 00002018",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0][63:32] : 32'h0);
        end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL b2b_beat%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (int'(count) !== exp_count) begin
            failures++;
            $display("[TB] FAIL b2b_count got=%0d required=%0d", count, exp_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        obs_q.delete(); exp_q.delete();
        stall_plan = '{0, 1000};
        csr = 32'h10;
        bus.wb_valid_i = 1'b1;
        bus.wb_desc_addr_i = 32'h0000_5000;
        bus.wb_status_i = 32'h1234_5678;
        bus.wb_ctrl_i = 32'h8000_0000;
        while (!(obs_q.size() == 1 && bus.dma_desc_wb_waitrequest_i && bus.dma_desc_wb_write_o) && n < 20) begin
            @(negedge clk);
            bus.wb_valid_i = 1'b0;
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("[TB] FAIL midburst_reach_ctrl beats=%0d required 1 beat then stalled ctrl beat", obs_q.size());
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.dma_desc_wb_write_o !== 1'b0 || count !== '0) begin
            failures++;
            $display("[TB] FAIL midburst_async write=%b count=%0d required 0/0", bus.dma_desc_wb_write_o, count);
        end
        stall_plan.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.wb_ready_o !== 1'b1 || bus.dma_desc_wb_write_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midburst_release ready=%b write=%b required 1/0", bus.wb_ready_o, bus.dma_desc_wb_write_o);
        end
        obs_q.delete(); exp_q.delete();
        exp_count = 0;
    endtask

    task automatic test_random();
        int lat, irqc, st0;
        bit ok;
        logic [31:0] a, s, c;
        rand_stalls = 1'b1;
        unstable_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            obs_q.delete(); exp_q.delete();
            a = $urandom(); s = $urandom(); c = $urandom();
            csr = $urandom();
            st0 = stall_total;
            run_one(a, s, c, lat, irqc, ok);
            checks++;
            if (!ok || lat != 4 + (stall_total - st0) || irqc != ((c[30] && csr[4]) ? 1 : 0)) begin
                failures++;
                $display("[TB] FAIL rand%0d_timing lat=%0d irq_cycles=%0d required lat=%0d irq=%0d",
                         k, lat, irqc, 4 + (stall_total - st0), (c[30] && csr[4]) ? 1 : 0);
            end
            checks++;
            if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                failures++;
                $display("[TB] FAIL rand%0d_beats got=%0d beats first=%h required=%h",
                         k, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, exp_q[0]);
            end
        end
        checks++;
        if (unstable_cnt != 0 || int'(count) !== exp_count) begin
            failures++;
            $display("[TB] FAIL rand_summary unstable=%0d count=%0d required 0/%0d", unstable_cnt, count, exp_count);
        end
        rand_stalls = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int lat, irqc;
        bit ok;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_count = 0;
        for (int k = 0; k < 17; k++) begin
            obs_q.delete(); exp_q.delete();
            run_one($urandom(), $urandom(), $urandom(), lat, irqc, ok);
        end
        checks++;
        if (count !== 4'd1 || exp_count != 1) begin
            failures++;
            $display("[TB] FAIL counter_wrap got=%0d required=1", count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_irq();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
